// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_pkg: opcode, ALU-select and FSM encodings plus the instruction decode helper
// shared by ctrl_sequencer, its interface and hazard_tracker.
package ctrl_pkg;

   localparam int PIPE_DEPTH_DEF = 4;
   localparam int NREG           = 16;
   localparam int RW             = $clog2(NREG);

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_OR    = 4'd4,
      OP_LOAD  = 4'd5,
      OP_STORE = 4'd6,
      OP_HALT  = 4'd15
   } op_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_DRAIN, ST_HALT} state_e;

   typedef struct packed {
      logic [1:0] alu_sel;
      logic       reg_we;
      logic       mem_we;
      logic       mem_to_reg;
      logic       mem_op;
      logic       src_a_vld;   // rs1, or rd for STORE
      logic       src_b_vld;   // rs2
      logic       halt;
      logic       undef;
   } dec_t;

   typedef struct packed {
      logic [1:0] alu_sel;
      logic       reg_we;
      logic       mem_we;
      logic       mem_to_reg;
      logic       mem_op;
      logic       pc_en;
      logic       bubble;
      logic       halted;
   } ctl_out_t;

   function automatic dec_t decode(input logic [3:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_NOP:   ;
         OP_ADD:   begin d.reg_we = 1'b1; d.alu_sel = ALU_ADD; d.src_a_vld = 1'b1; d.src_b_vld = 1'b1; end
         OP_SUB:   begin d.reg_we = 1'b1; d.alu_sel = ALU_SUB; d.src_a_vld = 1'b1; d.src_b_vld = 1'b1; end
         OP_AND:   begin d.reg_we = 1'b1; d.alu_sel = ALU_AND; d.src_a_vld = 1'b1; d.src_b_vld = 1'b1; end
         OP_OR:    begin d.reg_we = 1'b1; d.alu_sel = ALU_OR;  d.src_a_vld = 1'b1; d.src_b_vld = 1'b1; end
         OP_LOAD:  begin d.reg_we = 1'b1; d.mem_op = 1'b1; d.mem_to_reg = 1'b1; end
         OP_STORE: begin d.mem_we = 1'b1; d.mem_op = 1'b1; d.src_a_vld = 1'b1; end
         OP_HALT:  d.halt = 1'b1;
         default:  d.undef = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction fields in, datapath control strobes out.
// master = fetch/datapath side, slave = ctrl_sequencer.
interface ctrl_sequencer_if;
   import ctrl_pkg::*;

   logic [3:0]    opcode;
   logic [RW-1:0] rd;
   logic [RW-1:0] rs1;
   logic [RW-1:0] rs2;
   logic [2:0]    flag;
   logic [1:0]    alu_sel;
   logic          reg_write_en;
   logic          mem_write_en;
   logic          mem_to_reg;
   logic          mem_op;
   logic          pc_en;
   logic          bubble;
   logic          halted;
   logic          illegal;
   logic [2:0]    flag_q;

   modport master (
      output opcode, rd, rs1, rs2, flag,
      input  alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
             pc_en, bubble, halted, illegal, flag_q
   );

   modport slave (
      input  opcode, rd, rs1, rs2, flag,
      output alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
             pc_en, bubble, halted, illegal, flag_q
   );
endinterface

// File: rtl/ctrl_sequencer_hazard_tracker.sv
// hazard_tracker: raises o_stall while the current instruction may not issue.
// SCOREBOARD_EN defined: in-flight destination scoreboard; undefined: fixed issue-interval counter.
module hazard_tracker
   import ctrl_pkg::*;
#(
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_issue,
   input  logic          i_dest_vld,
   input  logic [RW-1:0] i_dest,
   input  logic          i_src_a_vld,
   input  logic [RW-1:0] i_src_a,
   input  logic          i_src_b_vld,
   input  logic [RW-1:0] i_src_b,
   output logic          o_stall
);
`ifdef SCOREBOARD_EN
   localparam int N = PIPE_DEPTH - 1;

   logic [N-1:0]         r_vld;
   logic [N-1:0][RW-1:0] r_rd;

   // Entry i holds the writer issued i+1 cycles ago; bubbles shift in valid=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         r_rd  <= '0;
      end else begin
         r_vld[0] <= i_issue & i_dest_vld;
         r_rd[0]  <= i_dest;
         for (int i = 1; i < N; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_rd[i]  <= r_rd[i-1];
         end
      end
   end

   always_comb begin
      o_stall = 1'b0;
      for (int i = 0; i < N; i++)
         if (r_vld[i] && ((i_src_a_vld && r_rd[i] == i_src_a) ||
                          (i_src_b_vld && r_rd[i] == i_src_b)))
            o_stall = 1'b1;
   end
`else
   localparam int CW = $clog2(PIPE_DEPTH);

   logic [CW-1:0] r_cnt;
   logic          w_unused;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_cnt <= '0;
      else if (i_issue)       r_cnt <= CW'(PIPE_DEPTH - 1);
      else if (r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
   end

   assign o_stall  = (r_cnt != '0);
   assign w_unused = ^{i_dest_vld, i_dest, i_src_a_vld, i_src_a, i_src_b_vld, i_src_b};
`endif
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: decodes instruction fields into registered datapath strobes and paces issue
// around RAW hazards; SCOREBOARD_EN selects the scoreboard flavour of hazard_tracker.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst,
   ctrl_sequencer_if.slave bus
);
   localparam int CW = $clog2(PIPE_DEPTH);

   state_e        r_state, w_next;
   ctl_out_t      r_out, w_out;
   logic [CW-1:0] r_drain, w_drain_nxt;
   logic          r_illegal;
   logic [2:0]    r_flag_q;
   dec_t          w_dec;
   logic          w_stall, w_issue;
   logic [RW-1:0] w_src_a;

   assign w_dec   = decode(bus.opcode);
   assign w_src_a = w_dec.mem_we ? bus.rd : bus.rs1;

   hazard_tracker #(.PIPE_DEPTH(PIPE_DEPTH)) u_haz (
      .clk         (clk),
      .rst         (rst),
      .i_issue     (w_issue),
      .i_dest_vld  (w_dec.reg_we),
      .i_dest      (bus.rd),
      .i_src_a_vld (w_dec.src_a_vld),
      .i_src_a     (w_src_a),
      .i_src_b_vld (w_dec.src_b_vld),
      .i_src_b     (bus.rs2),
      .o_stall     (w_stall)
   );

   always_comb begin
      w_next      = r_state;
      w_out       = '0;
      w_issue     = 1'b0;
      w_drain_nxt = r_drain;
      case (r_state)
         ST_RUN, ST_STALL: begin
            if (w_stall) begin
               w_next       = ST_STALL;
               w_out.bubble = 1'b1;
            end else begin
               w_issue          = 1'b1;
               w_out.alu_sel    = w_dec.alu_sel;
               w_out.reg_we     = w_dec.reg_we;
               w_out.mem_we     = w_dec.mem_we;
               w_out.mem_to_reg = w_dec.mem_to_reg;
               w_out.mem_op     = w_dec.mem_op;
               w_out.pc_en      = ~w_dec.halt;
               w_next           = w_dec.halt ? ST_DRAIN : ST_RUN;
               w_drain_nxt      = CW'(PIPE_DEPTH - 2);
            end
         end
         // PIPE_DEPTH-1 bubble cycles let the instructions ahead of HALT retire.
         ST_DRAIN: begin
            w_out.bubble = 1'b1;
            if (r_drain == '0) w_next = ST_HALT;
            else               w_drain_nxt = r_drain - CW'(1);
         end
         ST_HALT: begin
            w_out.bubble = 1'b1;
            w_out.halted = 1'b1;
         end
         default: w_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_out     <= '0;
         r_drain   <= '0;
         r_illegal <= 1'b0;
         r_flag_q  <= '0;
      end else begin
         r_state <= w_next;
         r_out   <= w_out;
         r_drain <= w_drain_nxt;
         if (w_issue)                r_flag_q  <= bus.flag;
         if (w_issue && w_dec.undef) r_illegal <= 1'b1;
      end
   end

   assign bus.alu_sel      = r_out.alu_sel;
   assign bus.reg_write_en = r_out.reg_we;
   assign bus.mem_write_en = r_out.mem_we;
   assign bus.mem_to_reg   = r_out.mem_to_reg;
   assign bus.mem_op       = r_out.mem_op;
   assign bus.pc_en        = r_out.pc_en;
   assign bus.bubble       = r_out.bubble;
   assign bus.halted       = r_out.halted;
   assign bus.illegal      = r_illegal;
   assign bus.flag_q       = r_flag_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: random and directed programs checked every cycle against a
// cycle-indexed issue model, plus literal expectations for the directed scenarios.
module tb_ctrl_sequencer;
   import ctrl_pkg::*;

   localparam int PD = PIPE_DEPTH_DEF;
`ifdef SCOREBOARD_EN
   localparam int GAP = 1;
`else
   localparam int GAP = PD;
`endif

   typedef struct packed {
      logic [1:0] alu;
      logic       rwe, mwe, m2r, mop, pc_en, bub, hlt, ill;
      logic [2:0] fq;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   ctrl_sequencer_if bus ();

   ctrl_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] prog[$];
   int          pc = 0;
   bit          flag_fix_en = 1'b0;
   logic [2:0]  flag_fix = 3'b000;
   out_t        obs[$];
   out_t        dv;
   out_t        exp_o;

   assign dv = {bus.alu_sel, bus.reg_write_en, bus.mem_write_en, bus.mem_to_reg, bus.mem_op,
                bus.pc_en, bus.bubble, bus.halted, bus.illegal, bus.flag_q};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
      return {4'(op), 4'(rd), 4'(rs1), 4'(rs2)};
   endfunction

   // ---------------- behavioural model: history of issue cycles ----------------
   int   m_cyc, m_halt_cyc, m_last_iss;
   int   hist_cyc[$];
   int   hist_rd[$];
   logic m_ill;
   logic [2:0] m_fq;

   function automatic bit reads(input int op, input int r, input int rd, input int rs1, input int rs2);
      if (op >= 1 && op <= 4) return (r == rs1) || (r == rs2);
      if (op == 6)            return r == rd;
      return 1'b0;
   endfunction

   task automatic m_reset();
      m_cyc = 0; m_halt_cyc = -1; m_last_iss = -1000;
      hist_cyc.delete(); hist_rd.delete();
      m_ill = 1'b0; m_fq = 3'b000; exp_o = '0;
   endtask

   task automatic m_step();
      int op, rd, rs1, rs2;
      bit stall;
      op = int'(bus.opcode); rd = int'(bus.rd); rs1 = int'(bus.rs1); rs2 = int'(bus.rs2);
      exp_o = '0; exp_o.ill = m_ill; exp_o.fq = m_fq;
      if (m_halt_cyc >= 0) begin
         exp_o.bub = 1'b1;
         exp_o.hlt = (m_cyc - m_halt_cyc >= PD);
      end else begin
         while (hist_cyc.size() > 0 && m_cyc - hist_cyc[0] > PD - 1) begin
            void'(hist_cyc.pop_front()); void'(hist_rd.pop_front());
         end
`ifdef SCOREBOARD_EN
         stall = 1'b0;
         foreach (hist_rd[i]) if (reads(op, hist_rd[i], rd, rs1, rs2)) stall = 1'b1;
`else
         stall = (m_cyc - m_last_iss <= PD - 1);
`endif
         if (stall) exp_o.bub = 1'b1;
         else begin
            m_last_iss = m_cyc;
            m_fq = bus.flag;
            case (op)
               1: begin exp_o.alu = 2'b00; exp_o.rwe = 1'b1; end
               2: begin exp_o.alu = 2'b01; exp_o.rwe = 1'b1; end
               3: begin exp_o.alu = 2'b10; exp_o.rwe = 1'b1; end
               4: begin exp_o.alu = 2'b11; exp_o.rwe = 1'b1; end
               5: begin exp_o.rwe = 1'b1; exp_o.m2r = 1'b1; exp_o.mop = 1'b1; end
               6: begin exp_o.mwe = 1'b1; exp_o.mop = 1'b1; end
               15: m_halt_cyc = m_cyc;
               0: ;
               default: m_ill = 1'b1;
            endcase
            if (op >= 1 && op <= 5) begin hist_cyc.push_back(m_cyc); hist_rd.push_back(rd); end
            exp_o.pc_en = (op != 15);
            exp_o.ill = m_ill;
            exp_o.fq = m_fq;
         end
      end
      m_cyc++;
   endtask

   always @(posedge clk) begin
      if (rst) m_reset();
      else     m_step();
   end

   // compare on the falling edge, away from the sampling edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("cycle_outputs", 32'(dv), 32'(exp_o));
         obs.push_back(dv);
      end
   end

   // fetch side: advance the PC when the model says this cycle issued
   always @(negedge clk) begin
      logic [15:0] ins;
      if (!rst && exp_o.pc_en) pc++;
      ins = (pc < prog.size()) ? prog[pc] : 16'h0000;
      {bus.opcode, bus.rd, bus.rs1, bus.rs2} = ins;
      bus.flag = flag_fix_en ? flag_fix : 3'($urandom);
   end

   task automatic run_prog(input int ncyc);
      @(negedge clk); #1 rst = 1'b1; m_reset();
      pc = 0;
      @(negedge clk); #1 rst = 1'b0;
      obs.delete();
      repeat (ncyc) @(negedge clk);
      #1;
   endtask

   task automatic first_two(output int i0, output int i1);
      i0 = -1; i1 = -1;
      foreach (obs[i]) if (!obs[i].bub && !obs[i].hlt) begin
         if (i0 < 0) i0 = i;
         else if (i1 < 0) i1 = i;
      end
   endtask

   function automatic logic [15:0] rand_instr();
      int r, op;
      r = int'($urandom_range(0, 19));
      if (r < 14)      op = 1 + (r % 6);
      else if (r < 16) op = 0;
      else if (r < 18) op = int'($urandom_range(7, 14));
      else             op = 1 + int'($urandom_range(0, 3));
      return enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, i1;
      bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.flag = '0;
      m_reset();
      #3 chk("reset_outputs", 32'(dv), 32'h0);

      // reset asserted mid-stall clears outputs at once; hazard state is discarded
      prog = {enc(1, 1, 2, 3), enc(4, 7, 1, 1)};
      run_prog(2);
      chk("T1_in_stall", 32'(obs[1].bub), 32'd1);
      rst = 1'b1; m_reset();
      #1 chk("T1_rst_zero", 32'(dv), 32'h0);
      prog = {enc(4, 7, 1, 1)}; pc = 0;
      @(negedge clk); #1 rst = 1'b0; obs.delete();
      @(negedge clk); #1;
      chk("T1_resume", {28'd0, obs[0].pc_en, obs[0].bub, obs[0].alu}, {28'd0, 4'b1011});

      // independent ALU ops
      prog = {enc(1, 1, 2, 3), enc(2, 4, 5, 6)};
      run_prog(12);
      first_two(i0, i1);
      chk("T2_found", 32'(i1 > i0 && i0 >= 0), 32'd1);
      if (i1 > i0 && i0 >= 0) begin
         chk("T2_gap", 32'(i1 - i0), 32'(GAP));
         chk("T2_add", {27'd0, obs[i0].alu, obs[i0].rwe, obs[i0].pc_en, obs[i0].bub}, {27'd0, 5'b00110});
         chk("T2_sub", {27'd0, obs[i1].alu, obs[i1].rwe, obs[i1].pc_en, obs[i1].bub}, {27'd0, 5'b01110});
      end

      // RAW on r1
      prog = {enc(1, 1, 2, 3), enc(4, 7, 1, 1)};
      run_prog(12);
      first_two(i0, i1);
      chk("T3_gap", 32'(i1 - i0), 32'd4);
      if (i1 >= 0) chk("T3_or", 32'(obs[i1].alu), 32'(2'b11));

      // LOAD r2 -> STORE r2
      prog = {enc(5, 2, 0, 0), enc(6, 2, 0, 0)};
      run_prog(12);
      first_two(i0, i1);
      chk("T4_gap", 32'(i1 - i0), 32'd4);
      if (i0 >= 0) chk("T4_load", {29'd0, obs[i0].mwe, obs[i0].mop, obs[i0].m2r}, 32'b011);
      if (i1 >= 0) chk("T4_store", {29'd0, obs[i1].mwe, obs[i1].mop, obs[i1].m2r}, 32'b110);

      // undefined opcode
      prog = {enc(9, 1, 2, 3), enc(1, 4, 5, 6)};
      run_prog(12);
      chk("T5_undef_issue", {28'd0, obs[0].ill, obs[0].rwe, obs[0].pc_en, obs[0].bub}, 32'b1010);
      chk("T5_sticky", 32'(obs[11].ill), 32'd1);

      // HALT
      flag_fix_en = 1'b1; flag_fix = 3'b101;
      prog = {enc(15, 0, 0, 0)};
      run_prog(12);
      chk("T6_flag_q", 32'(obs[0].fq), 32'b101);
      chk("T6_issue", {29'd0, obs[0].pc_en, obs[0].bub, obs[0].hlt}, 32'b000);
      for (int k = 1; k <= 3; k++)
         chk("T6_drain", {30'd0, obs[k].bub, obs[k].hlt}, 32'b10);
      chk("T6_halted", {29'd0, obs[4].pc_en, obs[4].bub, obs[4].hlt}, 32'b011);
      chk("T6_hold", {29'd0, obs[11].pc_en, obs[11].hlt, obs[11].fq == 3'b101}, 32'b011);
      flag_fix_en = 1'b0;

      // random programs ending in HALT
      for (int s = 0; s < 2; s++) begin
         prog.delete();
         for (int n = 0; n < 300; n++) prog.push_back(rand_instr());
         prog.push_back(enc(15, 0, 0, 0));
         run_prog(0);
         for (int n = 0; n < 4000 && !exp_o.hlt; n++) @(negedge clk);
         #1 chk("rand_halted", 32'(bus.halted), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
